// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, one-outstanding imem request, prefetch FIFO, redirect flush.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect targets set a sticky flag and halt fetching.
module fetch_unit #(
  parameter int              PC_W     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            misalign
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // state   | meaning
  // IDLE    | no request; waiting for FIFO room or un-halt
  // WAIT    | request outstanding at imem_addr, response will be pushed
  // DISCARD | request outstanding but redirected; response dropped on ack
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n, target;
  logic [CW-1:0]   count, count_n;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic            push, pop, misalign_n, room;

`ifndef FETCH_MISALIGN_EN
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
`endif

  always_comb begin
`ifdef FETCH_MISALIGN_EN
    target     = redirect_pc;
    misalign_n = redirect ? (redirect_pc[1:0] != 2'b00) : misalign;
`else
    target     = {redirect_pc[PC_W-1:2], 2'b00};
    misalign_n = 1'b0;
`endif
    push = (state == WAIT) && imem_ack && !redirect;
    pop  = inst_valid && inst_ready && !redirect;
    count_n = count;
    if (redirect)          count_n = '0;
    else if (push && !pop) count_n = count + CW'(1);
    else if (!push && pop) count_n = count - CW'(1);
    fetch_pc_n = redirect ? target : (push ? fetch_pc + PC_W'(4) : fetch_pc);
    // a free slot is reserved for every request before it is issued
    room = (count_n < FULL) && !misalign_n;
  end

  assign imem_req   = (state != IDLE);
  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      misalign  <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_n;
      misalign <= misalign_n;
      // address only moves once the outstanding request has been acknowledged
      if (!(imem_req && !imem_ack))
        imem_addr <= {fetch_pc_n[PC_W-1:2], 2'b00};
      case (state)
        IDLE:    state <= room ? WAIT : IDLE;
        WAIT: begin
          if (imem_ack)      state <= room ? WAIT : IDLE;
          else if (redirect) state <= DISCARD;
        end
        DISCARD: if (imem_ack) state <= room ? WAIT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      count <= count_n;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          mem_inst[wr_ptr] <= imem_rdata;
          mem_pc[wr_ptr]   <= fetch_pc;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc}; a monitor checks every pop.
module tb_fetch_unit;
  localparam int PC_W = 64;

  logic            clk, reset;
  logic            imem_req, imem_ack, inst_valid, inst_ready, redirect, misalign;
  logic [PC_W-1:0] imem_addr, inst_pc, redirect_pc;
  logic [31:0]     imem_rdata, inst;

  int n_vec = 0;
  int n_err = 0;
  int lat = 0;
  int lat_cnt = 0;
  int ack_cnt = 0;
  logic [63:0] exp_q[$];

  fetch_unit #(.PC_W(PC_W), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: word = address, ack after lat idle request cycles
  assign imem_ack   = imem_req && (lat_cnt >= lat);
  assign imem_rdata = imem_addr[31:0];
  always_ff @(posedge clk) begin
    if (!imem_req || imem_ack) lat_cnt <= 0;
    else                       lat_cnt <= lat_cnt + 1;
    if (imem_req && imem_ack)  ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: request-hold rule and scoreboard pops
  initial begin
    logic        hold_prev;
    logic [63:0] hold_addr, e;
    hold_prev = 1'b0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (hold_prev) begin
          chk("req_hold", 64'(imem_req), 64'd1);
          chk("addr_hold", imem_addr, hold_addr);
        end
        if (imem_req) chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
        hold_prev = imem_req && !imem_ack;
        hold_addr = imem_addr;
        if (inst_valid && inst_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pop: got pc %h expected none at %0t", inst_pc, $time);
          end else begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e);
            chk("inst", 64'(inst), 64'(e[31:0]));
          end
        end
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic wait_drain(input int max);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max && !done; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_addr"}, imem_addr, 64'd0);
    chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_pc"}, inst_pc, 64'd0);
    chk({tag, "_misalign"}, 64'(misalign), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; lat = 0;
    repeat (2) @(posedge clk); #1;
    chk_reset_vals("rst");

    // zero-wait streaming, one instruction per cycle
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    reset = 1'b1;
    chk("cycle0_idle", 64'(imem_req), 64'd0);
    @(posedge clk); #1;
    chk("cycle1_req", 64'(imem_req), 64'd1);
    chk("cycle1_addr", imem_addr, 64'd0);
    @(posedge clk); #1;
    chk("cycle2_valid", 64'(inst_valid), 64'd1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_gap", 64'(inst_valid), 64'd1);
      chk("req_high", 64'(imem_req), 64'd1);
    end
    wait_drain(20);

    // back-pressure fills exactly DEPTH entries
    begin
      int a0;
      inst_ready = 1'b0;
      do_reset();
      a0 = ack_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("full_acks", 64'(ack_cnt - a0), 64'd4);
      chk("full_req_off", 64'(imem_req), 64'd0);
      chk("full_valid", 64'(inst_valid), 64'd1);
      for (int i = 0; i < 6; i++) exp_q.push_back(64'(4 * i));
      inst_ready = 1'b1;
      wait_drain(30);
    end

    // slow memory, redirect while first request pending
    lat = 3;
    inst_ready = 1'b1;
    do_reset();
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 64'h40;
    exp_q.push_back(64'h40); exp_q.push_back(64'h44);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("discard_req", 64'(imem_req), 64'd1);
    chk("discard_addr", imem_addr, 64'd0);
    wait_drain(40);
    lat = 0;

    // redirect coinciding with ack and pop, two entries queued
    inst_ready = 1'b0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("two_queued", 64'(inst_valid), 64'd1);
    redirect = 1'b1; redirect_pc = 64'h80; inst_ready = 1'b1;
    exp_q.push_back(64'h80); exp_q.push_back(64'h84);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("flush_valid", 64'(inst_valid), 64'd0);
    chk("flush_addr", imem_addr, 64'h80);
    chk("flush_req", 64'(imem_req), 64'd1);
    wait_drain(20);

    // misaligned redirect target
    repeat (8) @(posedge clk);
    #1;
    chk("refill_idle", 64'(imem_req), 64'd0);
`ifdef FETCH_MISALIGN_EN
    redirect = 1'b1; redirect_pc = 64'h82; inst_ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("mis_set", 64'(misalign), 64'd1);
    chk("mis_valid", 64'(inst_valid), 64'd0);
    repeat (3) begin
      chk("mis_halt", 64'(imem_req), 64'd0);
      @(posedge clk); #1;
    end
    redirect = 1'b1; redirect_pc = 64'h84;
    exp_q.push_back(64'h84); exp_q.push_back(64'h88);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("mis_clear", 64'(misalign), 64'd0);
    chk("mis_resume_addr", imem_addr, 64'h84);
    chk("mis_resume_req", 64'(imem_req), 64'd1);
`else
    redirect = 1'b1; redirect_pc = 64'h82; inst_ready = 1'b1;
    exp_q.push_back(64'h80); exp_q.push_back(64'h84);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("align_addr", imem_addr, 64'h80);
    chk("align_misalign", 64'(misalign), 64'd0);
    chk("align_valid", 64'(inst_valid), 64'd0);
    chk("align_req", 64'(imem_req), 64'd1);
`endif
    wait_drain(20);

    // asynchronous reset mid-operation
    inst_ready = 1'b0;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(inst_valid), 64'd1);
    chk("pre_rst_req", 64'(imem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("post_rst_idle", 64'(imem_req), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_req", 64'(imem_req), 64'd1);
    chk("post_rst_addr", imem_addr, 64'd0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h4);
    inst_ready = 1'b1;
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
